multicycle_ctrl: RTL and testbench

//  Multi-cycle sequencer for the MIPS-subset datapath (reg file, ALU, EXT, operand/dest muxes).

---
 rtl/mc_pkg.sv | 17 +
 rtl/mc_decode.sv | 33 +++
 rtl/multicycle_ctrl.sv | 90 +++++++++
 tb/tb_multicycle_ctrl.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// mc_pkg: opcode/funct constants, ALU and PC-source encodings, controller state and decode types.
package mc_pkg;
  localparam logic [5:0] OP_R = 6'h00, OP_ADDI = 6'h08, OP_ANDI = 6'h0C, OP_ORI = 6'h0D;
  localparam logic [5:0] OP_LW = 6'h23, OP_SW = 6'h2B, OP_BEQ = 6'h04, OP_BNE = 6'h05, OP_J = 6'h02;
  localparam logic [5:0] FN_ADD = 6'h20, FN_SUB = 6'h22, FN_AND = 6'h24, FN_OR = 6'h25;
  localparam logic [1:0] ALU_ADD = 2'b00, ALU_SUB = 2'b01, ALU_AND = 2'b10, ALU_OR = 2'b11;
  localparam logic [1:0] PC_4 = 2'b00, PC_BR = 2'b01, PC_J = 2'b10;
  typedef enum logic [2:0] {S_IF, S_ID, S_EX, S_MEM, S_WB, S_TRAP} state_t;
  typedef enum logic [2:0] {C_ILL, C_R, C_IMM, C_LW, C_SW, C_BEQ, C_BNE, C_J} cls_t;
  typedef struct packed {
    logic       regrt;
    logic       se;
    logic       aluqb;
    logic [1:0] aluc;
    logic       reg2reg;
  } dec_t;
endpackage

// File: rtl/mc_decode.sv
// mc_decode: combinational Op/Func decode into instruction class and datapath select signals.
module mc_decode
  import mc_pkg::*;
(
  input  logic [5:0] op_i,
  input  logic [5:0] func_i,
  output cls_t       cls_o,
  output dec_t       dec_o,
  output logic       legal_o
);
  always_comb begin
    cls_o = C_ILL;
    case (op_i)
      OP_R: cls_o = func_i inside {FN_ADD, FN_SUB, FN_AND, FN_OR} ? C_R : C_ILL;
      OP_ADDI, OP_ANDI, OP_ORI: cls_o = C_IMM;
      OP_LW: cls_o = C_LW;
      OP_SW: cls_o = C_SW;
      OP_BEQ: cls_o = C_BEQ;
      OP_BNE: cls_o = C_BNE;
      OP_J: cls_o = C_J;
      default: ;
    endcase
    dec_o.regrt = cls_o inside {C_IMM, C_LW, C_SW};
    dec_o.se = cls_o inside {C_LW, C_SW, C_BEQ, C_BNE} || (cls_o == C_IMM && op_i == OP_ADDI);
    dec_o.aluqb = cls_o inside {C_R, C_BEQ, C_BNE};
    dec_o.aluc = cls_o == C_R ? (func_i == FN_SUB ? ALU_SUB : func_i == FN_AND ? ALU_AND :
                                 func_i == FN_OR ? ALU_OR : ALU_ADD)
               : cls_o == C_IMM ? (op_i == OP_ANDI ? ALU_AND : op_i == OP_ORI ? ALU_OR : ALU_ADD)
               : cls_o inside {C_BEQ, C_BNE} ? ALU_SUB : ALU_ADD;
    dec_o.reg2reg = cls_o == C_LW;
  end
  assign legal_o = cls_o != C_ILL;
endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: IF/ID/EX/MEM/WB sequencer sharing one memory port, with timeout and sticky error flags.
module multicycle_ctrl
  import mc_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int RET_W = 32
) (
  input  logic             Clk,
  input  logic             Clrn,
  input  logic [5:0]       Op,
  input  logic [5:0]       Func,
  input  logic             Z,
  input  logic             Mem_rdy,
  output logic             Mem_req,
  output logic             Iord,
  output logic             Wmem,
  output logic             Irwr,
  output logic             Pcwr,
  output logic [1:0]       Pcsrc,
  output logic             Regrt,
  output logic             Se,
  output logic             Aluqb,
  output logic [1:0]       Aluc,
  output logic             Wreg,
  output logic             Reg2reg,
  output logic             Illegal,
  output logic             Bus_err,
  output logic [RET_W-1:0] Retired
);
  localparam int WW = $clog2(MEM_TIMEOUT + 1) + 1;
  localparam logic [WW-1:0] TLIM = WW'(MEM_TIMEOUT - 1);
  state_t state_q;
  logic run_q, ill_q, berr_q;
  logic [WW-1:0] wait_q;
  logic [RET_W-1:0] ret_q;
  cls_t cls;
  dec_t dec;
  logic legal, req, done, tout, br, retire;
  mc_decode u_dec (.op_i(Op), .func_i(Func), .cls_o(cls), .dec_o(dec), .legal_o(legal));
  // run_q holds requests off until the first edge after reset release
  always_comb begin
    req = run_q && (state_q == S_IF || state_q == S_MEM);
    done = req && Mem_rdy;
    tout = req && !Mem_rdy && MEM_TIMEOUT != 0 && wait_q == TLIM;
    br = cls == C_BEQ || cls == C_BNE;
    retire = (state_q == S_ID && cls == C_J) || (state_q == S_EX && br) ||
             (state_q == S_MEM && done && cls == C_SW) || state_q == S_WB;
    Mem_req = req;
    Iord = req && state_q == S_MEM;
    Wmem = Iord && cls == C_SW;
    Irwr = done && state_q == S_IF;
    Pcwr = Irwr || (state_q == S_ID && cls == C_J) ||
           (state_q == S_EX && ((cls == C_BEQ && Z) || (cls == C_BNE && !Z)));
    Pcsrc = state_q == S_ID && cls == C_J ? PC_J : state_q == S_EX && br ? PC_BR : PC_4;
    {Regrt, Se, Aluqb, Aluc, Reg2reg} = state_q != S_IF && state_q != S_TRAP ? dec : '0;
    Wreg = state_q == S_WB;
    Illegal = ill_q;
    Bus_err = berr_q;
    Retired = ret_q;
  end
  always_ff @(posedge Clk or negedge Clrn)
    if (!Clrn) begin
      state_q <= S_IF;
      run_q <= 1'b0;
      wait_q <= '0;
      ret_q <= '0;
      ill_q <= 1'b0;
      berr_q <= 1'b0;
    end else begin
      run_q <= 1'b1;
      wait_q <= req && !Mem_rdy ? wait_q + 1'b1 : '0;
      if (retire) ret_q <= ret_q + 1'b1;
      if (tout) begin
        state_q <= S_TRAP;
        berr_q <= 1'b1;
      end else
        case (state_q)
          S_IF: if (done) state_q <= S_ID;
          S_ID:
            if (!legal) begin
              state_q <= S_TRAP;
              ill_q <= 1'b1;
            end else state_q <= cls == C_J ? S_IF : S_EX;
          S_EX: state_q <= br ? S_IF : cls == C_LW || cls == C_SW ? S_MEM : S_WB;
          S_MEM: if (done) state_q <= cls == C_SW ? S_IF : S_WB;
          S_WB: state_q <= S_IF;
          default: ;
        endcase
    end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed and random instruction sequences checked against a per-instruction phase model.
module tb_multicycle_ctrl;
  localparam int TO = 16;
  logic Clk = 0, Clrn = 0, Z = 0, Mem_rdy = 0;
  logic [5:0] Op = 0, Func = 0;
  logic Mem_req, Iord, Wmem, Irwr, Pcwr, Regrt, Se, Aluqb, Wreg, Reg2reg, Illegal, Bus_err;
  logic [1:0] Pcsrc, Aluc;
  logic [31:0] Retired;
  logic m4, i4, w4, ir4, pw4, rt4, se4, qb4, wr4, r2_4, il4, be4;
  logic [1:0] ps4, ac4;
  logic [3:0] Retired4;
  logic [31:0] cnt = 0;
  int checks = 0, errors = 0;

  multicycle_ctrl dut (.Clk(Clk), .Clrn(Clrn), .Op(Op), .Func(Func), .Z(Z), .Mem_rdy(Mem_rdy),
    .Mem_req(Mem_req), .Iord(Iord), .Wmem(Wmem), .Irwr(Irwr), .Pcwr(Pcwr), .Pcsrc(Pcsrc),
    .Regrt(Regrt), .Se(Se), .Aluqb(Aluqb), .Aluc(Aluc), .Wreg(Wreg), .Reg2reg(Reg2reg),
    .Illegal(Illegal), .Bus_err(Bus_err), .Retired(Retired));
  multicycle_ctrl #(.RET_W(4)) dut4 (.Clk(Clk), .Clrn(Clrn), .Op(Op), .Func(Func), .Z(Z),
    .Mem_rdy(Mem_rdy), .Mem_req(m4), .Iord(i4), .Wmem(w4), .Irwr(ir4), .Pcwr(pw4), .Pcsrc(ps4),
    .Regrt(rt4), .Se(se4), .Aluqb(qb4), .Aluc(ac4), .Wreg(wr4), .Reg2reg(r2_4),
    .Illegal(il4), .Bus_err(be4), .Retired(Retired4));

  wire [13:0] o  = {Mem_req, Iord, Wmem, Irwr, Pcwr, Pcsrc, Regrt, Se, Aluqb, Aluc, Wreg, Reg2reg};
  wire [13:0] o4 = {m4, i4, w4, ir4, pw4, ps4, rt4, se4, qb4, ac4, wr4, r2_4};

  initial forever #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // class: 0 illegal, 1 R, 2 imm, 3 lw, 4 sw, 5 beq, 6 bne, 7 j; d = {regrt,se,aluqb,aluc,reg2reg}
  function automatic void mdec(input logic [5:0] op, input logic [5:0] fn, output int k,
                               output logic [5:0] d);
    k = 0;
    d = 6'b0;
    case (op)
      6'h00:
        case (fn)
          6'h20: begin k = 1; d = 6'b001000; end
          6'h22: begin k = 1; d = 6'b001010; end
          6'h24: begin k = 1; d = 6'b001100; end
          6'h25: begin k = 1; d = 6'b001110; end
          default: ;
        endcase
      6'h08: begin k = 2; d = 6'b110000; end
      6'h0C: begin k = 2; d = 6'b100100; end
      6'h0D: begin k = 2; d = 6'b100110; end
      6'h23: begin k = 3; d = 6'b110001; end
      6'h2B: begin k = 4; d = 6'b110000; end
      6'h04: begin k = 5; d = 6'b011010; end
      6'h05: begin k = 6; d = 6'b011010; end
      6'h02: begin k = 7; d = 6'b000000; end
      default: ;
    endcase
  endfunction

  function automatic logic [13:0] ev(input logic mq, input logic io, input logic wm, input logic ir,
                                     input logic pw, input logic [1:0] ps, input logic [5:0] d,
                                     input logic wr);
    return {mq, io, wm, ir, pw, ps, d[5:1], wr, d[0]};
  endfunction

  task automatic cyc(input string tag, input logic [13:0] e);
    #3;
    chk(tag, o, e);
    chk({tag, "/r4"}, o4, e);
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Clrn = 0;
    #1;
    chk("rst outs", o, 0);
    chk("rst flags", {Illegal, Bus_err, il4, be4}, 0);
    chk("rst retired", {Retired, Retired4}, 0);
    @(posedge Clk);
    #1;
    Clrn = 1;
    cnt = 0;
    #3;
    chk("pre-first-edge", o, 0);
    @(posedge Clk);
    #1;
  endtask

  task automatic mphase(input string tag, input logic io, input logic wm, input int w,
                        input logic [5:0] d, output logic tr);
    tr = 1;
    for (int i = 0; i < TO; i++) begin
      Mem_rdy = (i == w);
      cyc(tag, ev(1, io, wm, !io && Mem_rdy, !io && Mem_rdy, 2'b00, d, 0));
      if (i == w) begin
        tr = 0;
        break;
      end
    end
  endtask

  task automatic trapped(input logic [1:0] flags);
    for (int i = 0; i < 20; i++) begin
      Mem_rdy = 1'($urandom);
      cyc("trap", 0);
    end
    chk("trap flags", {Illegal, Bus_err}, flags);
    chk("trap flags4", {il4, be4}, flags);
    chk("trap retired", Retired, cnt);
    do_reset();
  endtask

  task automatic run(input logic [5:0] op, input logic [5:0] fn, input logic z, input int iw,
                     input int mw);
    int k;
    logic [5:0] d;
    logic tr;
    logic [3:0] c4;
    mdec(op, fn, k, d);
    c4 = cnt[3:0];
    chk("retired", Retired, cnt);
    chk("retired4", Retired4, c4);
    chk("flags", {Illegal, Bus_err}, 0);
    Op = op;
    Func = fn;
    Z = z;
    mphase("if", 0, 0, iw, 6'b0, tr);
    if (tr) begin trapped(2'b01); return; end
    Mem_rdy = 1'($urandom);
    if (k == 0) begin
      cyc("id ill", 0);
      trapped(2'b10);
      return;
    end
    if (k == 7) begin
      cyc("id j", ev(0, 0, 0, 0, 1, 2'b10, d, 0));
      cnt++;
      return;
    end
    cyc("id", ev(0, 0, 0, 0, 0, 2'b00, d, 0));
    Mem_rdy = 1'($urandom);
    if (k == 5 || k == 6) begin
      cyc("ex br", ev(0, 0, 0, 0, k == 5 ? z : !z, 2'b01, d, 0));
      cnt++;
      return;
    end
    cyc("ex", ev(0, 0, 0, 0, 0, 2'b00, d, 0));
    if (k == 3 || k == 4) begin
      mphase("mem", 1, k == 4, mw, d, tr);
      if (tr) begin trapped(2'b01); return; end
      if (k == 4) begin cnt++; return; end
    end
    Mem_rdy = 1'($urandom);
    cyc("wb", ev(0, 0, 0, 0, 0, 2'b00, d, 1));
    cnt++;
  endtask

  logic [5:0] ops[12] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h08, 6'h0C, 6'h0D, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02};
  logic [5:0] fns[4] = '{6'h20, 6'h22, 6'h24, 6'h25};

  initial begin
    int k;
    logic [5:0] d, f;
    do_reset();
    run(6'h00, 6'h20, 0, 0, 0);
    run(6'h23, 6'h11, 0, 3, 3);
    run(6'h04, 6'h00, 1, 0, 0);
    run(6'h04, 6'h00, 0, 0, 0);
    run(6'h05, 6'h00, 1, 1, 0);
    run(6'h05, 6'h00, 0, 0, 0);
    run(6'h02, 6'h3F, 0, 2, 0);
    run(6'h08, 6'h00, 0, 0, 0);
    run(6'h0C, 6'h00, 0, 0, 0);
    run(6'h0D, 6'h00, 0, 0, 0);
    run(6'h2B, 6'h00, 0, 0, 2);
    run(6'h23, 6'h00, 0, 15, 15);
    for (int i = 0; i < 40; i++) begin
      int j;
      j = $urandom_range(11);
      f = j < 4 ? fns[j] : 6'($urandom);
      run(ops[j], f, 1'($urandom), $urandom_range(4), $urandom_range(4));
    end
    run(6'h3F, 6'h00, 0, 0, 0);
    run(6'h00, 6'h20, 0, 0, 0);
    run(6'h00, 6'h21, 0, 1, 0);
    run(6'h2B, 6'h00, 0, 0, 20);
    run(6'h00, 6'h25, 0, 16, 0);
    run(6'h00, 6'h22, 0, 0, 0);
    Op = 6'h2B;
    Func = 6'h00;
    mdec(Op, Func, k, d);
    Mem_rdy = 1;
    cyc("sw if", ev(1, 0, 0, 1, 1, 2'b00, 6'b0, 0));
    Mem_rdy = 0;
    cyc("sw id", ev(0, 0, 0, 0, 0, 2'b00, d, 0));
    cyc("sw ex", ev(0, 0, 0, 0, 0, 2'b00, d, 0));
    #3;
    chk("sw mem", o, ev(1, 1, 1, 0, 0, 2'b00, d, 0));
    do_reset();
    run(6'h00, 6'h24, 0, 0, 0);
    chk("final retired", Retired, cnt);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
